matmul_seq: RTL and testbench

Sequencer for the 4x4 parallel matrix-multiply datapath. It accepts a job (source and destination base addresses), clears the datapath, and streams the A/B operand beats from operand memory into the datapath. It waits out the multiplier latency, then drains the result columns to result memory and reports completion. It sits between the system command interface, the operand/result memories and the multiply datapath, and owns the datapath's `read_en`, `write_en` and local clear.

---
 rtl/matmul_pkg.sv | 29 ++
 rtl/matmul_seq_beat_counter.sv | 22 ++
 rtl/matmul_seq.sv | 140 ++++++++++++++
 tb/tb_matmul_seq.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared types and sizing for the 4x4 matrix-multiply sequencer and datapath.
package matmul_pkg;

   localparam int WIDTH_DEF        = 8;
   localparam int MATRIX_WIDTH_DEF = 4;
   localparam int ADDR_WIDTH_DEF   = 8;

   // Two elements per operand beat, one column per result beat.
   function automatic int load_beats(input int n);
      return n * n / 2;
   endfunction

   function automatic int drain_beats(input int n);
      return n;
   endfunction

   localparam int LOAD_BEATS  = load_beats(MATRIX_WIDTH_DEF);
   localparam int DRAIN_BEATS = drain_beats(MATRIX_WIDTH_DEF);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_LOAD,
      ST_COMPUTE,
      ST_DRAIN,
      ST_DONE
   } mm_state_t;

endpackage

// File: rtl/matmul_seq_beat_counter.sv
// Up-counter with synchronous clear, enable and a terminal-count compare.
module beat_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   input  logic [W-1:0] last,
   output logic [W-1:0] count,
   output logic         tc
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      count <= '0;
      else if (clr) count <= '0;
      else if (en)  count <= count + 1'b1;
   end

   assign tc = (count == last);

endmodule

// File: rtl/matmul_seq.sv
// Job sequencer for the matrix-multiply datapath: clear, load operands,
// wait out the multiplier, drain results, report completion or abort.
module matmul_seq
   import matmul_pkg::*;
#(
   parameter int WIDTH        = WIDTH_DEF,
   parameter int MATRIX_WIDTH = MATRIX_WIDTH_DEF,
   parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
   parameter int MUL_LATENCY  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] src_base,
   input  logic [ADDR_WIDTH-1:0] dst_base,
   output logic                  rd_req,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_gnt,
   input  logic                  rd_valid,
   output logic                  mm_clear,
   output logic                  mm_read_en,
   output logic                  mm_write_en,
   input  logic                  mm_write_ready,
   output logic                  wr_req,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted
);

   // state   | meaning
   // IDLE    | waiting for start
   // CLEAR   | one-cycle datapath clear, counters zeroed
   // LOAD    | issuing operand reads, forwarding returned beats
   // COMPUTE | waiting MUL_LATENCY cycles for the multiplier
   // DRAIN   | writing result columns as the datapath presents them
   // DONE    | one-cycle completion pulse

   localparam int LB = load_beats(MATRIX_WIDTH);
   localparam int DB = drain_beats(MATRIX_WIDTH);
   localparam int CW = $clog2(LB + 1);
   localparam int WW = $clog2(DB + 1);
   localparam int LW = $clog2(MUL_LATENCY + 1);

   localparam logic [CW-1:0] LB_C   = CW'(LB);
   localparam logic [CW-1:0] LB_M1  = CW'(LB - 1);
   localparam logic [WW-1:0] DB_M1  = WW'(DB - 1);
   localparam logic [LW-1:0] LAT_M1 = LW'(MUL_LATENCY - 1);

   mm_state_t state, state_nxt;
   logic [ADDR_WIDTH-1:0] src_q, dst_q;
   logic [CW-1:0] issue_cnt, issued_nxt, rcv_cnt;
   logic [WW-1:0] wr_cnt;
   logic [LW-1:0] lat_cnt;
   logic issue_en, issue_tc, rcv_en, rcv_tc, lat_tc, wr_tc;
   logic rd_req_nxt, abort_hit;
   logic [31:0] unused_bits;

   assign issue_en    = rd_req & rd_gnt;
   assign rcv_en      = (state == ST_LOAD) & rd_valid;
   assign mm_read_en  = rcv_en;
   assign mm_write_en = (state == ST_DRAIN);
   assign wr_req      = (state == ST_DRAIN) & mm_write_ready & ~abort;
   assign wr_addr     = dst_q + ADDR_WIDTH'(wr_cnt);

   beat_counter #(.W(CW)) u_issue (
      .clk(clk), .rst(reset), .clr(state == ST_CLEAR), .en(issue_en),
      .last(LB_C), .count(issue_cnt), .tc(issue_tc)
   );

   beat_counter #(.W(CW)) u_rcv (
      .clk(clk), .rst(reset), .clr(state == ST_CLEAR), .en(rcv_en),
      .last(LB_M1), .count(rcv_cnt), .tc(rcv_tc)
   );

   beat_counter #(.W(LW)) u_lat (
      .clk(clk), .rst(reset), .clr(state != ST_COMPUTE), .en(state == ST_COMPUTE),
      .last(LAT_M1), .count(lat_cnt), .tc(lat_tc)
   );

   beat_counter #(.W(WW)) u_wr (
      .clk(clk), .rst(reset), .clr(state == ST_CLEAR), .en(wr_req),
      .last(DB_M1), .count(wr_cnt), .tc(wr_tc)
   );

   assign unused_bits = 32'(WIDTH) ^ 32'({issue_tc, rcv_cnt, lat_cnt});

   always_comb begin
      state_nxt = state;
      abort_hit = 1'b0;
      case (state)
         ST_IDLE:    if (start) state_nxt = ST_CLEAR;
         ST_CLEAR:   state_nxt = ST_LOAD;
         ST_LOAD:    if (rd_valid && rcv_tc) state_nxt = ST_COMPUTE;
         ST_COMPUTE: if (lat_tc) state_nxt = ST_DRAIN;
         ST_DRAIN:   if (wr_req && wr_tc) state_nxt = ST_DONE;
         ST_DONE:    state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
      if (state != ST_IDLE && abort) begin
         state_nxt = ST_IDLE;
         abort_hit = 1'b1;
      end
   end

   // Read request/address are registered, so they are built from the
   // post-edge issue count.
   always_comb begin
      issued_nxt = (state == ST_CLEAR) ? '0 : issue_cnt + CW'(issue_en);
      rd_req_nxt = (state_nxt == ST_LOAD) && (issued_nxt != LB_C);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= ST_IDLE;
         busy     <= 1'b0;
         done     <= 1'b0;
         aborted  <= 1'b0;
         mm_clear <= 1'b0;
         rd_req   <= 1'b0;
         rd_addr  <= '0;
         src_q    <= '0;
         dst_q    <= '0;
      end else begin
         state    <= state_nxt;
         busy     <= (state_nxt != ST_IDLE);
         done     <= (state_nxt == ST_DONE);
         aborted  <= abort_hit;
         mm_clear <= (state_nxt == ST_CLEAR);
         rd_req   <= rd_req_nxt;
         if (rd_req_nxt) rd_addr <= src_q + ADDR_WIDTH'(issued_nxt);
         if (state == ST_IDLE && start) begin
            src_q <= src_base;
            dst_q <= dst_base;
         end
      end
   end

endmodule

// File: tb/tb_matmul_seq.sv
// Directed bench for matmul_seq: nominal, backpressure, wrap, abort,
// ignored inputs, back-to-back and asynchronous reset mid-job.
module tb_matmul_seq;

   logic clk = 1'b0;
   logic reset, start, abort, rd_gnt, rd_valid, mm_write_ready;
   logic [7:0] src_base, dst_base;
   logic rd_req, mm_clear, mm_read_en, mm_write_en, wr_req, busy, done, aborted;
   logic [7:0] rd_addr, wr_addr;

   matmul_seq dut (
      .clk(clk), .reset(reset), .start(start), .abort(abort),
      .src_base(src_base), .dst_base(dst_base),
      .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid),
      .mm_clear(mm_clear), .mm_read_en(mm_read_en), .mm_write_en(mm_write_en),
      .mm_write_ready(mm_write_ready), .wr_req(wr_req), .wr_addr(wr_addr),
      .busy(busy), .done(done), .aborted(aborted)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   int rd_cnt, rdq_cyc, re_cnt, wr_cnt, clear_cnt, clear_cyc, done_cnt, done_cyc;
   int abort_cnt, abort_cyc, end_cyc, first_rd, last_rd, first_re, last_re;
   int first_wr, last_wr, rd_after_abort, abort_drv;
   bit timed_out;
   logic [7:0] rd_addrs [16];
   logic [7:0] wr_addrs [8];
   logic [23:0] rst_snap;

   // Runs one job with start in cycle 0 (the current cycle). Returns at the
   // sample point of the first cycle in which busy is low again.
   task automatic run_job(input logic [7:0] src, input logic [7:0] dst,
                          input bit toggle_gnt, input int stall, input int abort_rcv,
                          input int stray_cyc, input int busy_start_cyc, input int reset_cyc);
      logic vpend;
      int dcyc;
      bit abort_sent, fin;
      vpend = 1'b0; dcyc = 0; abort_sent = 1'b0; fin = 1'b0;
      rd_cnt = 0; rdq_cyc = 0; re_cnt = 0; wr_cnt = 0; clear_cnt = 0; clear_cyc = -1;
      done_cnt = 0; done_cyc = -1; abort_cnt = 0; abort_cyc = -1; end_cyc = -1;
      first_rd = -1; last_rd = -1; first_re = -1; last_re = -1; first_wr = -1; last_wr = -1;
      rd_after_abort = 0; abort_drv = -1; timed_out = 1'b0; rst_snap = '1;
      for (int cyc = 0; cyc < 100 && !fin; cyc++) begin
         start    = (cyc == 0) || (cyc == busy_start_cyc);
         src_base = (cyc == 0) ? src : 8'h5A;
         dst_base = (cyc == 0) ? dst : 8'hA5;
         rd_gnt   = toggle_gnt ? (cyc % 2 == 0) : 1'b1;
         rd_valid = vpend || (cyc == stray_cyc);
         abort    = 1'b0;
         if (abort_rcv > 0 && !abort_sent && re_cnt == abort_rcv) begin
            abort = 1'b1; abort_sent = 1'b1; abort_drv = cyc;
         end
         mm_write_ready = mm_write_en && (dcyc >= stall);
         #4;
         if (rd_req) begin
            rdq_cyc++;
            if (first_rd < 0) first_rd = cyc;
            last_rd = cyc;
            if (rd_gnt) begin
               if (rd_cnt < 16) rd_addrs[rd_cnt] = rd_addr;
               rd_cnt++;
            end
            if (abort_drv >= 0 && cyc > abort_drv) rd_after_abort++;
         end
         if (mm_read_en) begin
            re_cnt++;
            if (first_re < 0) first_re = cyc;
            last_re = cyc;
         end
         if (wr_req) begin
            if (wr_cnt < 8) wr_addrs[wr_cnt] = wr_addr;
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
         end
         if (mm_write_en) dcyc++;
         if (mm_clear) begin clear_cnt++; clear_cyc = cyc; end
         if (done) begin done_cnt++; done_cyc = cyc; end
         if (aborted) begin abort_cnt++; abort_cyc = cyc; end
         if (cyc > 0 && !busy) begin fin = 1'b1; end_cyc = cyc; end
         vpend = rd_req && rd_gnt;
         if (!fin) begin
            if (cyc == reset_cyc) begin
               #2 reset = 1'b1;
               #1 rst_snap = {busy, done, aborted, mm_clear, rd_req, mm_read_en,
                              mm_write_en, wr_req, rd_addr, wr_addr};
               @(posedge clk); #1 reset = 1'b0;
            end else begin
               @(posedge clk); #1;
            end
         end
      end
      start = 1'b0; abort = 1'b0; rd_valid = 1'b0; mm_write_ready = 1'b0;
      if (!fin) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; abort = 1'b0; rd_gnt = 1'b0; rd_valid = 1'b0;
      mm_write_ready = 1'b0; src_base = 8'h33; dst_base = 8'h44;
      #12;
      n_cmp++;
      if ({busy, done, aborted, mm_clear, rd_req, mm_read_en, mm_write_en, wr_req, rd_addr, wr_addr} !== 24'h0) begin
         n_err++;
         $display("FAIL reset_outputs: got %b/%h/%h want all zero",
                  {busy, done, aborted, mm_clear, rd_req, mm_read_en, mm_write_en, wr_req}, rd_addr, wr_addr);
      end
      @(posedge clk); #1 reset = 1'b0;
      abort = 1'b1;
      @(posedge clk); #4;
      n_cmp++;
      if ({busy, aborted} !== 2'b00) begin
         n_err++; $display("FAIL idle_abort: got busy/aborted=%b want 00", {busy, aborted});
      end
      abort = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_nominal();
      run_job(8'h10, 8'h80, 1'b0, 0, 0, -1, -1, -1);
      n_cmp++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL nom_timeout: got %0d want 0", timed_out); end
      n_cmp++; if (clear_cyc !== 1 || clear_cnt !== 1) begin n_err++; $display("FAIL nom_clear: got cyc %0d cnt %0d want 1 1", clear_cyc, clear_cnt); end
      n_cmp++; if (first_rd !== 2 || last_rd !== 9 || rd_cnt !== 8) begin n_err++; $display("FAIL nom_rd_window: got %0d-%0d n%0d want 2-9 n8", first_rd, last_rd, rd_cnt); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (rd_addrs[i] !== 8'(8'h10 + i)) begin n_err++; $display("FAIL nom_rd_addr[%0d]: got %h want %h", i, rd_addrs[i], 8'(8'h10 + i)); end
      end
      n_cmp++; if (first_re !== 3 || last_re !== 10 || re_cnt !== 8) begin n_err++; $display("FAIL nom_read_en: got %0d-%0d n%0d want 3-10 n8", first_re, last_re, re_cnt); end
      n_cmp++; if (first_wr !== 15 || last_wr !== 18 || wr_cnt !== 4) begin n_err++; $display("FAIL nom_wr_window: got %0d-%0d n%0d want 15-18 n4", first_wr, last_wr, wr_cnt); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (wr_addrs[i] !== 8'(8'h80 + i)) begin n_err++; $display("FAIL nom_wr_addr[%0d]: got %h want %h", i, wr_addrs[i], 8'(8'h80 + i)); end
      end
      n_cmp++; if (done_cyc !== 19 || done_cnt !== 1 || abort_cnt !== 0) begin n_err++; $display("FAIL nom_done: got cyc %0d n%0d ab%0d want 19 n1 ab0", done_cyc, done_cnt, abort_cnt); end
      n_cmp++; if (end_cyc !== 20) begin n_err++; $display("FAIL nom_idle: got %0d want 20", end_cyc); end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure();
      run_job(8'h20, 8'h70, 1'b1, 3, 0, -1, -1, -1);
      n_cmp++; if (rd_cnt !== 8 || rdq_cyc !== 15 || last_rd !== 16) begin n_err++; $display("FAIL bp_reads: got n%0d req%0d last%0d want n8 req15 last16", rd_cnt, rdq_cyc, last_rd); end
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (rd_addrs[i] !== 8'(8'h20 + i)) begin n_err++; $display("FAIL bp_rd_addr[%0d]: got %h want %h", i, rd_addrs[i], 8'(8'h20 + i)); end
      end
      n_cmp++; if (re_cnt !== 8 || last_re !== 17) begin n_err++; $display("FAIL bp_read_en: got n%0d last%0d want n8 last17", re_cnt, last_re); end
      n_cmp++; if (wr_cnt !== 4 || first_wr !== 25 || last_wr !== 28) begin n_err++; $display("FAIL bp_writes: got n%0d %0d-%0d want n4 25-28", wr_cnt, first_wr, last_wr); end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (wr_addrs[i] !== 8'(8'h70 + i)) begin n_err++; $display("FAIL bp_wr_addr[%0d]: got %h want %h", i, wr_addrs[i], 8'(8'h70 + i)); end
      end
      n_cmp++; if (done_cyc !== 29 || end_cyc !== 30) begin n_err++; $display("FAIL bp_done: got %0d/%0d want 29/30", done_cyc, end_cyc); end
      @(posedge clk); #1;
   endtask

   task automatic test_wrap();
      run_job(8'hFC, 8'hFE, 1'b0, 0, 0, -1, -1, -1);
      for (int i = 0; i < 8; i++) begin
         n_cmp++;
         if (rd_addrs[i] !== 8'(8'hFC + i)) begin n_err++; $display("FAIL wrap_rd_addr[%0d]: got %h want %h", i, rd_addrs[i], 8'(8'hFC + i)); end
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (wr_addrs[i] !== 8'(8'hFE + i)) begin n_err++; $display("FAIL wrap_wr_addr[%0d]: got %h want %h", i, wr_addrs[i], 8'(8'hFE + i)); end
      end
      n_cmp++; if (done_cyc !== 19 || rd_cnt !== 8 || wr_cnt !== 4) begin n_err++; $display("FAIL wrap_done: got %0d r%0d w%0d want 19 r8 w4", done_cyc, rd_cnt, wr_cnt); end
      @(posedge clk); #1;
   endtask

   task automatic test_abort();
      run_job(8'h10, 8'h80, 1'b0, 0, 3, -1, -1, -1);
      n_cmp++; if (abort_drv !== 6) begin n_err++; $display("FAIL abort_drive: got %0d want 6", abort_drv); end
      n_cmp++; if (abort_cnt !== 1 || abort_cyc !== 7 || end_cyc !== 7) begin n_err++; $display("FAIL abort_pulse: got n%0d cyc%0d end%0d want n1 7 7", abort_cnt, abort_cyc, end_cyc); end
      n_cmp++; if (done_cnt !== 0 || wr_cnt !== 0) begin n_err++; $display("FAIL abort_no_done: got done%0d wr%0d want 0 0", done_cnt, wr_cnt); end
      n_cmp++; if (rd_after_abort !== 0) begin n_err++; $display("FAIL abort_rd_after: got %0d want 0", rd_after_abort); end
      n_cmp++; if (re_cnt !== 4) begin n_err++; $display("FAIL abort_read_en: got %0d want 4", re_cnt); end
      @(posedge clk); #1;
      run_job(8'h20, 8'h40, 1'b0, 0, 0, -1, -1, -1);
      n_cmp++; if (clear_cnt !== 1 || clear_cyc !== 1) begin n_err++; $display("FAIL abort_next_clear: got n%0d cyc%0d want 1 1", clear_cnt, clear_cyc); end
      n_cmp++; if (rd_cnt !== 8 || re_cnt !== 8 || wr_cnt !== 4 || done_cyc !== 19) begin n_err++; $display("FAIL abort_next_job: got r%0d re%0d w%0d d%0d want 8 8 4 19", rd_cnt, re_cnt, wr_cnt, done_cyc); end
      n_cmp++; if (rd_addrs[7] !== 8'h27 || wr_addrs[3] !== 8'h43) begin n_err++; $display("FAIL abort_next_addr: got %h/%h want 27/43", rd_addrs[7], wr_addrs[3]); end
      @(posedge clk); #1;
   endtask

   task automatic test_ignored_inputs();
      run_job(8'h30, 8'h60, 1'b0, 0, 0, 12, 5, -1);
      n_cmp++; if (clear_cnt !== 1) begin n_err++; $display("FAIL ign_clear: got %0d want 1", clear_cnt); end
      n_cmp++; if (re_cnt !== 8 || last_re !== 10) begin n_err++; $display("FAIL ign_read_en: got n%0d last%0d want n8 last10", re_cnt, last_re); end
      n_cmp++; if (rd_addrs[0] !== 8'h30 || rd_addrs[7] !== 8'h37) begin n_err++; $display("FAIL ign_rd_addr: got %h/%h want 30/37", rd_addrs[0], rd_addrs[7]); end
      n_cmp++; if (wr_addrs[0] !== 8'h60 || wr_addrs[3] !== 8'h63) begin n_err++; $display("FAIL ign_wr_addr: got %h/%h want 60/63", wr_addrs[0], wr_addrs[3]); end
      n_cmp++; if (done_cyc !== 19 || end_cyc !== 20) begin n_err++; $display("FAIL ign_timing: got %0d/%0d want 19/20", done_cyc, end_cyc); end
   endtask

   // Starts in the idle cycle that ends the previous job.
   task automatic test_back_to_back();
      run_job(8'h44, 8'h90, 1'b0, 0, 0, -1, -1, -1);
      n_cmp++; if (clear_cyc !== 1 || first_rd !== 2) begin n_err++; $display("FAIL b2b_start: got clear%0d rd%0d want 1 2", clear_cyc, first_rd); end
      n_cmp++; if (done_cyc !== 19 || rd_addrs[0] !== 8'h44 || wr_addrs[3] !== 8'h93) begin n_err++; $display("FAIL b2b_job: got d%0d %h %h want 19 44 93", done_cyc, rd_addrs[0], wr_addrs[3]); end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_drain();
      run_job(8'h10, 8'h80, 1'b0, 0, 0, -1, -1, 16);
      n_cmp++; if (rst_snap !== 24'h0) begin n_err++; $display("FAIL rst_outputs: got %h want 000000", rst_snap); end
      n_cmp++; if (wr_cnt !== 2 || done_cnt !== 0 || abort_cnt !== 0 || end_cyc !== 17) begin n_err++; $display("FAIL rst_discard: got w%0d d%0d a%0d end%0d want 2 0 0 17", wr_cnt, done_cnt, abort_cnt, end_cyc); end
      @(posedge clk); #1;
      run_job(8'h00, 8'hC0, 1'b0, 0, 0, -1, -1, -1);
      n_cmp++; if (clear_cnt !== 1 || done_cyc !== 19 || wr_cnt !== 4 || wr_addrs[0] !== 8'hC0 || wr_addrs[3] !== 8'hC3) begin
         n_err++; $display("FAIL rst_next_job: got c%0d d%0d w%0d %h %h want 1 19 4 c0 c3", clear_cnt, done_cyc, wr_cnt, wr_addrs[0], wr_addrs[3]);
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_backpressure();
      test_wrap();
      test_abort();
      test_ignored_inputs();
      test_back_to_back();
      test_reset_mid_drain();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
